// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions: operand-mux select codes and the
// per-stage destination tracking record used by the forwarding unit.
package fwd_hazard_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;
  localparam logic [1:0] FWD_ZERO    = 2'd3;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } track_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// Per-operand forwarding priority: unused, zero register, youngest
// producer (EX) first, then MEM; WB needs nothing as the regfile is write-through.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter logic [REG_W-1:0] ZERO_REG = '0
) (
  input  logic             uses,
  input  logic [REG_W-1:0] src,
  input  track_entry_t     ex_e,
  input  track_entry_t     mem_e,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_REGFILE;
    if (!uses) begin
      sel = FWD_REGFILE;
    end else if (src == ZERO_REG) begin
      sel = FWD_ZERO;
    end else if (ex_e.reg_write && (ex_e.rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_e.reg_write && (mem_e.rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard controller. Tracks EX/MEM/WB
// destinations, registers the EX operand-mux selects, raises a combinational stall.
module fwd_hazard_unit #(
  parameter int                     REG_W    = fwd_hazard_unit_pkg::REG_W,
  parameter logic [REG_W-1:0]       ZERO_REG = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [REG_W-1:0]                  id_rs,
  input  logic [REG_W-1:0]                  id_rt,
  input  logic                              id_uses_rs,
  input  logic                              id_uses_rt,
  input  logic [REG_W-1:0]                  id_rd,
  input  logic                              id_reg_write,
  input  logic                              id_mem_read,
  input  logic                              flush,
  output logic                              stall,
  output logic [1:0]                        fwd_a_sel,
  output logic [1:0]                        fwd_b_sel,
  output fwd_hazard_unit_pkg::track_entry_t dbg_ex,
  output fwd_hazard_unit_pkg::track_entry_t dbg_mem,
  output fwd_hazard_unit_pkg::track_entry_t dbg_wb
);
  import fwd_hazard_unit_pkg::*;

  track_entry_t ex_q, mem_q, wb_q;
  track_entry_t id_e;
  logic [1:0]   sel_a, sel_b;
  logic         take;

  assign id_e = '{rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  // A load still in EX cannot supply its data until MEM, so a reader must wait one cycle.
  assign stall = id_valid && !flush && ex_q.mem_read && ex_q.reg_write &&
                 (ex_q.rd != ZERO_REG) &&
                 ((id_uses_rs && (id_rs == ex_q.rd)) ||
                  (id_uses_rt && (id_rt == ex_q.rd)));

  assign take = id_valid && !flush && !stall;

  fwd_select #(.ZERO_REG(ZERO_REG)) u_sel_a (
    .uses  (id_uses_rs),
    .src   (id_rs),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .sel   (sel_a)
  );

  fwd_select #(.ZERO_REG(ZERO_REG)) u_sel_b (
    .uses  (id_uses_rt),
    .src   (id_rt),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .sel   (sel_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= FWD_REGFILE;
      fwd_b_sel <= FWD_REGFILE;
    end else begin
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      ex_q      <= take ? id_e : '0;
      fwd_a_sel <= take ? sel_a : FWD_REGFILE;
      fwd_b_sel <= take ? sel_b : FWD_REGFILE;
    end
  end

  assign dbg_ex  = ex_q;
  assign dbg_mem = mem_q;
  assign dbg_wb  = wb_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: history-based model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  track_entry_t dbg_ex, dbg_mem, dbg_wb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  ent_t       hist[3];

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .dbg_ex       (dbg_ex),
    .dbg_mem      (dbg_mem),
    .dbg_wb       (dbg_wb)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
  function automatic logic [1:0] model_sel(input logic uses, input logic [4:0] src);
    if (!uses) return 2'd0;
    if (src == 5'd0) return 2'd3;
    for (int age = 0; age < 2; age++)
      if (hist[age].wr && hist[age].rd == src) return 2'(age + 1);
    return 2'd0;
  endfunction

  function automatic logic model_stall();
    if (!id_valid || flush) return 1'b0;
    if (!(hist[0].ld && hist[0].wr) || hist[0].rd == 5'd0) return 1'b0;
    return (id_uses_rs && id_rs == hist[0].rd) || (id_uses_rt && id_rt == hist[0].rd);
  endfunction

  function automatic logic model_take();
    return id_valid && !flush && !model_stall();
  endfunction

  function automatic logic [3:0] pop_exp();
    if (exp_q.size() == 0) return 4'd0;
    return exp_q.pop_front();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_take() ? {model_sel(id_uses_rs, id_rs), model_sel(id_uses_rt, id_rt)}
                                   : 4'd0);
      hist[0] <= model_take() ? {id_rd, id_reg_write, id_mem_read} : 7'd0;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_sel_ab", {4'd0, fwd_a_sel, fwd_b_sel}, {4'd0, pop_exp()});
      check("model_stall", {7'd0, stall}, {7'd0, model_stall()});
      check("model_ex", {1'b0, dbg_ex}, {1'b0, hist[0]});
      check("model_mem", {1'b0, dbg_mem}, {1'b0, hist[1]});
      check("model_wb", {1'b0, dbg_wb}, {1'b0, hist[2]});
    end
  end

  task automatic issue(input logic v, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut, input logic [4:0] rd,
                       input logic wr, input logic ld);
    @(posedge clk);
    #1;
    id_valid = v; flush = fl; id_rs = rs; id_rt = rt;
    id_uses_rs = ur; id_uses_rt = ut; id_rd = rd;
    id_reg_write = wr; id_mem_read = ld;
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    issue(1'b1, 1'b0, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs);
    issue(1'b1, 1'b0, rs, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop();
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'd0);
    check("reset_stall", {7'd0, stall}, 8'd0);

    // Asynchronous reset while a load-use hazard is pending
    alu(5'd1, 5'd2, 5'd3);
    lw(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd5);
    check("pre_rst_sel_a", {6'd0, fwd_a_sel}, 8'd1);
    check("pre_rst_stall", {7'd0, stall}, 8'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'd0);
    check("async_rst_stall", {7'd0, stall}, 8'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    alu(5'd6, 5'd5, 5'd5);
    check("post_rst_stall", {7'd0, stall}, 8'd0);
    nop();
    check("post_rst_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'd0);

    // EX/MEM, MEM/WB and write-through distances
    drain();
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd8, 5'd3, 5'd4);
    nop();
    check("exmem_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'b0000_0100);
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd9, 5'd1, 5'd2);
    alu(5'd10, 5'd3, 5'd2);
    nop();
    check("memwb_sel_a", {6'd0, fwd_a_sel}, 8'd2);
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd9, 5'd1, 5'd2);
    alu(5'd11, 5'd1, 5'd2);
    alu(5'd12, 5'd3, 5'd2);
    nop();
    check("wb_dist_sel_a", {6'd0, fwd_a_sel}, 8'd0);

    // Youngest producer wins; rs==rt gives identical selects
    alu(5'd7, 5'd1, 5'd2);
    alu(5'd7, 5'd2, 5'd1);
    alu(5'd13, 5'd7, 5'd7);
    nop();
    check("priority_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'b0000_0101);

    // Load-use: one stall, bubble, then MEM/WB forward
    drain();
    lw(5'd4, 5'd1);
    alu(5'd5, 5'd1, 5'd4);
    check("lu_stall", {7'd0, stall}, 8'd1);
    alu(5'd5, 5'd1, 5'd4);
    check("lu_stall_once", {7'd0, stall}, 8'd0);
    check("lu_bubble_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'd0);
    nop();
    check("lu_fwd", {4'd0, fwd_a_sel, fwd_b_sel}, 8'b0000_0010);

    // Back-to-back dependent loads each stall once
    drain();
    lw(5'd4, 5'd1);
    lw(5'd6, 5'd4);
    check("b2b_stall_1", {7'd0, stall}, 8'd1);
    lw(5'd6, 5'd4);
    check("b2b_release_1", {7'd0, stall}, 8'd0);
    alu(5'd7, 5'd6, 5'd6);
    check("b2b_stall_2", {7'd0, stall}, 8'd1);
    alu(5'd7, 5'd6, 5'd6);
    check("b2b_release_2", {7'd0, stall}, 8'd0);

    // Zero register never forwards and never stalls
    drain();
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd14, 5'd0, 5'd0);
    nop();
    check("zero_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'b0000_1111);
    lw(5'd0, 5'd1);
    alu(5'd14, 5'd0, 5'd0);
    check("zero_no_stall", {7'd0, stall}, 8'd0);
    nop();
    check("zero_after_lw", {4'd0, fwd_a_sel, fwd_b_sel}, 8'b0000_1111);

    // Flush overrides stall and inserts a bubble
    drain();
    lw(5'd9, 5'd1);
    issue(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    check("flush_stall", {7'd0, stall}, 8'd0);
    alu(5'd15, 5'd9, 5'd2);
    check("flush_next_stall", {7'd0, stall}, 8'd0);
    check("flush_bubble_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'd0);
    nop();
    check("flush_fwd_sel", {4'd0, fwd_a_sel, fwd_b_sel}, 8'b0000_1000);

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
